// File: rtl/rv32_mod_mem_arbiter.sv
// Two-to-one req/ack arbiter sharing one memory port between fetch and LSU, with a BUSY watchdog.
// Define RV32_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests (default: data has priority).
module rv32_mod_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic        i_err,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [31:0] mem_rdata,
  output logic        grant_d
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  // A zero-width counter is illegal, so a disabled watchdog keeps a 1-bit dummy.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          busy_i, busy_d, live, timeout_hit, resp_ack, resp_err, pick_d;

  assign busy_i = (state == BUSY_I);
  assign busy_d = (state == BUSY_D);

  // Dropping the granted request aborts the transaction in the same cycle.
  assign live        = (busy_i & i_req) | (busy_d & d_req);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
  // Error outranks ack; ack outranks the watchdog.
  assign resp_err    = live & (mem_err | (timeout_hit & ~mem_ack));
  assign resp_ack    = live & mem_ack & ~mem_err;

`ifdef RV32_ARB_ROUND_ROBIN_EN
  assign pick_d = d_req & (~i_req | ~grant_d);
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (pick_d)     state_nxt = BUSY_D;
        else if (i_req) state_nxt = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (!live || resp_ack || resp_err) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      grant_d <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        cnt <= '0;
        if (state_nxt != IDLE) grant_d <= (state_nxt == BUSY_D);
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign mem_req   = live;
  assign mem_wr    = busy_d & d_wr;
  assign mem_be    = busy_d ? d_be    : (busy_i ? 4'hF   : 4'h0);
  assign mem_addr  = busy_d ? d_addr  : (busy_i ? i_addr : 32'h0);
  assign mem_wdata = busy_d ? d_wdata : 32'h0;

  assign i_ack   = busy_i & resp_ack;
  assign i_err   = busy_i & resp_err;
  assign i_rdata = i_ack ? mem_rdata : 32'h0;
  assign d_ack   = busy_d & resp_ack;
  assign d_err   = busy_d & resp_err;
  assign d_rdata = d_ack ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_rv32_mod_mem_arbiter.sv
// Self-checking bench for rv32_mod_mem_arbiter: directed scenarios with literal expectations,
// then random traffic compared every cycle against a transaction-level ownership model.
module tb_rv32_mod_mem_arbiter;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack, i_err;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0, d_wr = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_ack, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0, mem_err = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        grant_d;

  int n_cmp = 0;
  int n_fail = 0;

  rv32_mod_mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata),
    .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the memory port (0 none, 1 fetch, 2 data) and for how many cycles.
  int owner = 0;
  int age = 0;
  bit last_d = 1'b0;

  function automatic bit owner_live();
    return (owner == 1) ? i_req : ((owner == 2) ? d_req : 1'b0);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit take_d;
    if (!reset_n) begin
      owner = 0; age = 0; last_d = 1'b0;
    end else if (owner == 0) begin
      if (i_req || d_req) begin
`ifdef RV32_ARB_ROUND_ROBIN_EN
        take_d = d_req && (!i_req || !last_d);
`else
        take_d = d_req;
`endif
        owner  = take_d ? 2 : 1;
        age    = 0;
        last_d = take_d;
      end
    end else if (!owner_live() || mem_ack || mem_err || age == T - 1) begin
      owner = 0;
    end else begin
      age++;
    end
  end

  // Compare process: checks every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    bit live, ack, err;
    live = owner_live();
    err  = live && (mem_err || (age == T - 1 && !mem_ack));
    ack  = live && mem_ack && !mem_err;
    check("m_mem_req", mem_req, live);
    if (live) begin
      check("m_mem_wr",    mem_wr,    (owner == 2) ? d_wr : 1'b0);
      check("m_mem_be",    mem_be,    (owner == 2) ? d_be : 4'hF);
      check("m_mem_addr",  mem_addr,  (owner == 2) ? d_addr : i_addr);
      check("m_mem_wdata", mem_wdata, (owner == 2) ? d_wdata : 32'h0);
    end
    check("m_i_ack",   i_ack,   owner == 1 && ack);
    check("m_i_err",   i_err,   owner == 1 && err);
    check("m_i_rdata", i_rdata, (owner == 1 && ack) ? mem_rdata : 32'h0);
    check("m_d_ack",   d_ack,   owner == 2 && ack);
    check("m_d_err",   d_err,   owner == 2 && err);
    check("m_d_rdata", d_rdata, (owner == 2 && ack) ? mem_rdata : 32'h0);
    check("m_grant_d", grant_d, last_d);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    bit exp_d, i_done, d_done;

    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    smp();
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_grant_d", grant_d, 1'b0);
    check("rst_i_ack", i_ack, 1'b0);
    check("rst_d_err", d_err, 1'b0);

    // Single fetch, memory answers in the second BUSY cycle.
    step(); i_req = 1; i_addr = 32'h1000_0000; smp();
    check("t1_idle_no_req", mem_req, 1'b0);
    step(); smp();
    check("t1_mem_req", mem_req, 1'b1);
    check("t1_mem_be", mem_be, 4'hF);
    check("t1_mem_wr", mem_wr, 1'b0);
    check("t1_mem_addr", mem_addr, 32'h1000_0000);
    step(); mem_ack = 1; mem_rdata = 32'h0000_0013; smp();
    check("t1_i_ack", i_ack, 1'b1);
    check("t1_i_rdata", i_rdata, 32'h0000_0013);
    check("t1_d_ack", d_ack, 1'b0);
    step(); i_req = 0; mem_ack = 0; mem_rdata = 0; smp();
    check("t1_after_idle", mem_req, 1'b0);

    // Simultaneous fetch + store: data first either way (last grant was fetch).
    step();
    i_req = 1; i_addr = 32'h0000_0100;
    d_req = 1; d_wr = 1; d_be = 4'hF; d_addr = 32'h8000_0004; d_wdata = 32'hDEAD_BEEF;
    smp();
    step(); smp();
    check("t2_grant_d", grant_d, 1'b1);
    check("t2_mem_wr", mem_wr, 1'b1);
    check("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    step(); mem_ack = 1; smp();
    check("t2_d_ack", d_ack, 1'b1);
    check("t2_i_ack_held", i_ack, 1'b0);
    step(); d_req = 0; d_wr = 0; mem_ack = 0; smp();
    check("t2_idle_gap", mem_req, 1'b0);
    step(); smp();
    check("t2_fetch_req", mem_req, 1'b1);
    check("t2_fetch_addr", mem_addr, 32'h0000_0100);
    check("t2_grant_i", grant_d, 1'b0);
    step(); mem_ack = 1; smp();
    check("t2_i_ack", i_ack, 1'b1);
    step(); i_req = 0; mem_ack = 0; smp();

    // Load error.
    step(); d_req = 1; d_wr = 0; d_addr = 32'hFFFF_FFF0; smp();
    step(); mem_err = 1; smp();
    check("t3_d_err", d_err, 1'b1);
    check("t3_d_ack", d_ack, 1'b0);
    step(); d_req = 0; mem_err = 0; smp();
    check("t3_idle", mem_req, 1'b0);
    check("t3_err_pulse", d_err, 1'b0);

    // Simultaneous pair after a data transaction.
`ifdef RV32_ARB_ROUND_ROBIN_EN
    exp_d = 1'b0;
`else
    exp_d = 1'b1;
`endif
    step(); i_req = 1; i_addr = 32'h200; d_req = 1; d_addr = 32'h300; smp();
    step(); smp();
    check("t3b_first_grant", grant_d, exp_d);
    check("t3b_first_addr", mem_addr, exp_d ? 32'h300 : 32'h200);
    step(); mem_ack = 1; smp();
    check("t3b_first_ack", exp_d ? d_ack : i_ack, 1'b1);
    step(); mem_ack = 0; if (exp_d) d_req = 0; else i_req = 0; smp();
    step(); smp();
    check("t3b_second_grant", grant_d, !exp_d);
    step(); mem_ack = 1; smp();
    check("t3b_second_ack", exp_d ? i_ack : d_ack, 1'b1);
    step(); mem_ack = 0; i_req = 0; d_req = 0; smp();

    // Watchdog: no response, error in BUSY cycle T, late ack ignored.
    step(); d_req = 1; d_addr = 32'h400; smp();
    for (int k = 1; k <= T; k++) begin
      step(); smp();
      check($sformatf("t4_d_err_c%0d", k), d_err, (k == T));
    end
    step(); d_req = 0; smp();
    check("t4_mem_req_off", mem_req, 1'b0);
    step(); mem_ack = 1; smp();
    check("t4_late_i_ack", i_ack, 1'b0);
    check("t4_late_d_ack", d_ack, 1'b0);
    step(); mem_ack = 0; smp();

    // Async reset mid-BUSY_D with a pending fetch.
    step(); d_req = 1; d_wr = 1; d_addr = 32'h700; d_wdata = 32'h55; smp();
    step(); i_req = 1; i_addr = 32'h800; smp();
    check("t5_busy_d", mem_req, 1'b1);
    check("t5_grant_d", grant_d, 1'b1);
    #1 mem_ack = 1; reset_n = 0;
    #1;
    check("t5_rst_mem_req", mem_req, 1'b0);
    check("t5_rst_d_ack", d_ack, 1'b0);
    check("t5_rst_d_err", d_err, 1'b0);
    check("t5_rst_grant_d", grant_d, 1'b0);
    d_req = 0; d_wr = 0; mem_ack = 0;
    step(); reset_n = 1; smp();
    check("t5_idle_after_rst", mem_req, 1'b0);
    step(); smp();
    check("t5_fetch_granted", mem_req, 1'b1);
    check("t5_fetch_addr", mem_addr, 32'h800);
    step(); mem_ack = 1; smp();
    check("t5_i_ack", i_ack, 1'b1);
    step(); i_req = 0; mem_ack = 0; smp();

    // Abort of a granted fetch, then a normal fetch.
    step(); i_req = 1; i_addr = 32'h500; smp();
    step(); smp();
    check("t6_busy", mem_req, 1'b1);
    step(); i_req = 0; mem_ack = 1; smp();
    check("t6_abort_mem_req", mem_req, 1'b0);
    check("t6_abort_i_ack", i_ack, 1'b0);
    check("t6_abort_i_err", i_err, 1'b0);
    step(); mem_ack = 0; i_req = 1; i_addr = 32'h600; smp();
    step(); smp();
    check("t6_next_req", mem_req, 1'b1);
    check("t6_next_addr", mem_addr, 32'h600);
    step(); mem_ack = 1; mem_rdata = 32'hCAFE_F00D; smp();
    check("t6_i_ack", i_ack, 1'b1);
    check("t6_i_rdata", i_rdata, 32'hCAFE_F00D);
    step(); i_req = 0; mem_ack = 0; mem_rdata = 0; smp();

    // Random traffic, checked by the compare process.
    for (int c = 0; c < 3000; c++) begin
      smp();
      i_done = i_ack | i_err;
      d_done = d_ack | d_err;
      step();
      if (i_req && i_done) begin
        i_req = ($urandom_range(0, 3) == 0);
        i_addr = $urandom;
      end else if (i_req && $urandom_range(0, 49) == 0) begin
        i_req = 0;
      end else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1; i_addr = $urandom;
      end
      if (d_req && d_done) begin
        d_req = ($urandom_range(0, 3) == 0);
        d_wr = $urandom_range(0, 1); d_be = 4'($urandom); d_addr = $urandom; d_wdata = $urandom;
      end else if (d_req && $urandom_range(0, 49) == 0) begin
        d_req = 0;
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1;
        d_wr = $urandom_range(0, 1); d_be = 4'($urandom); d_addr = $urandom; d_wdata = $urandom;
      end
      mem_ack   = ($urandom_range(0, 3) == 0);
      mem_err   = ($urandom_range(0, 9) == 0);
      mem_rdata = $urandom;
    end

    step(); i_req = 0; d_req = 0; mem_ack = 0; mem_err = 0;
    repeat (3) smp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
